// File: rtl/kernel_ctrl_pkg.sv
// Register map, AP_CTRL bit positions and FSM state types shared by kernel_ctrl_s_axi.
package kernel_ctrl_pkg;

    localparam logic [5:0] ADDR_AP_CTRL = 6'h00;
    localparam logic [5:0] ADDR_GIE     = 6'h04;
    localparam logic [5:0] ADDR_IER     = 6'h08;
    localparam logic [5:0] ADDR_ISR     = 6'h0C;
    localparam logic [5:0] ADDR_PTR0_LO = 6'h10;
    localparam logic [5:0] ADDR_PTR0_HI = 6'h14;

    localparam int AP_START_BIT     = 0;
    localparam int AP_DONE_BIT      = 1;
    localparam int AP_IDLE_BIT      = 2;
    localparam int AP_READY_BIT     = 3;
    localparam int AUTO_RESTART_BIT = 7;

    typedef enum logic [1:0] {
        WRIDLE,
        WRDATA,
        WRRESP
    } wr_state_e;

    typedef enum logic {
        RDIDLE,
        RDDATA
    } rd_state_e;

    // Byte-lane merge of a write into a 32-bit register.
    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/kernel_ctrl_s_axi.sv
// AXI4-Lite control slave for the kernel: ap_ctrl handshake, interrupt and the 64-bit pointer argument.
// Build option: define KCTRL_AUTO_RESTART_EN to implement the AP_CTRL auto_restart bit.
module kernel_ctrl_s_axi
    import kernel_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            s_axi_control_awvalid,
    output logic                            s_axi_control_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                            s_axi_control_wvalid,
    output logic                            s_axi_control_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                            s_axi_control_bvalid,
    input  logic                            s_axi_control_bready,
    output logic [1:0]                      s_axi_control_bresp,
    input  logic                            s_axi_control_arvalid,
    output logic                            s_axi_control_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                            s_axi_control_rvalid,
    input  logic                            s_axi_control_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                      s_axi_control_rresp,
    output logic                            interrupt,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_idle,
    input  logic                            ap_ready,
    output logic [63:0]                     axi00_ptr0
);

    wr_state_e wstate_q;
    logic [5:0] waddr_q;
    logic       awready_q, wready_q, bvalid_q;

    rd_state_e  rstate_q;
    logic       arready_q, rvalid_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [31:0] rd_mux;

    logic        ap_start_q, ap_start_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        gie_q, gie_d;
    logic [1:0]  ier_q, ier_d;
    logic [1:0]  isr_q, isr_d;
    logic [63:0] ptr_q, ptr_d;
    logic        interrupt_q;
    logic        auto_restart;

    logic aw_hs, w_hs, ar_hs;
    logic wr_ctrl, wr_gie, wr_ier, wr_isr, wr_lo, wr_hi, rd_ctrl;
    logic [5:0] raddr;
    logic unused_addr_bits;

    // Only the low six address bits take part in decode.
    assign unused_addr_bits = ^{s_axi_control_awaddr[C_S_AXI_ADDR_WIDTH-1:6],
                                s_axi_control_araddr[C_S_AXI_ADDR_WIDTH-1:6]};

    assign aw_hs = s_axi_control_awvalid & awready_q;
    assign w_hs  = s_axi_control_wvalid  & wready_q;
    assign ar_hs = s_axi_control_arvalid & arready_q;
    assign raddr = s_axi_control_araddr[5:0];

    assign wr_ctrl = w_hs && (waddr_q == ADDR_AP_CTRL) && s_axi_control_wstrb[0];
    assign wr_gie  = w_hs && (waddr_q == ADDR_GIE)     && s_axi_control_wstrb[0];
    assign wr_ier  = w_hs && (waddr_q == ADDR_IER)     && s_axi_control_wstrb[0];
    assign wr_isr  = w_hs && (waddr_q == ADDR_ISR)     && s_axi_control_wstrb[0];
    assign wr_lo   = w_hs && (waddr_q == ADDR_PTR0_LO);
    assign wr_hi   = w_hs && (waddr_q == ADDR_PTR0_HI);
    assign rd_ctrl = ar_hs && (raddr == ADDR_AP_CTRL);

    // Write channel: address, then data, then response; never aw and w together.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wstate_q  <= WRIDLE;
            waddr_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
            case (wstate_q)
                WRIDLE: begin
                    if (aw_hs) begin
                        waddr_q   <= s_axi_control_awaddr[5:0];
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= WRDATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                WRDATA: begin
                    if (w_hs) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        wstate_q <= WRRESP;
                    end
                end
                WRRESP: begin
                    if (s_axi_control_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= WRIDLE;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    wstate_q  <= WRIDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (raddr)
            ADDR_AP_CTRL: begin
                rd_mux[AP_START_BIT]     = ap_start_q;
                rd_mux[AP_DONE_BIT]      = done_q;
                rd_mux[AP_IDLE_BIT]      = ap_idle;
                rd_mux[AP_READY_BIT]     = ready_q;
                rd_mux[AUTO_RESTART_BIT] = auto_restart;
            end
            ADDR_GIE:     rd_mux[0]   = gie_q;
            ADDR_IER:     rd_mux[1:0] = ier_q;
            ADDR_ISR:     rd_mux[1:0] = isr_q;
            ADDR_PTR0_LO: rd_mux      = ptr_q[31:0];
            ADDR_PTR0_HI: rd_mux      = ptr_q[63:32];
            default:      rd_mux      = '0;
        endcase
    end

    // Read data is captured at the AR handshake and held until the host takes it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rstate_q  <= RDIDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                RDIDLE: begin
                    if (ar_hs) begin
                        rdata_q   <= rd_mux;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rstate_q  <= RDDATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RDDATA: begin
                    if (s_axi_control_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= RDIDLE;
                    end
                end
                default: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                    rstate_q  <= RDIDLE;
                end
            endcase
        end
    end

`ifdef KCTRL_AUTO_RESTART_EN
    logic auto_restart_q, auto_restart_d;

    assign auto_restart_d = wr_ctrl ? s_axi_control_wdata[AUTO_RESTART_BIT] : auto_restart_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) auto_restart_q <= 1'b0;
        else           auto_restart_q <= auto_restart_d;
    end

    assign auto_restart = auto_restart_q;
`else
    assign auto_restart = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value is defaulted first so no path leaves a latch.
        ap_start_d = ap_start_q;
        ptr_d      = ptr_q;

        if (wr_ctrl && s_axi_control_wdata[AP_START_BIT]) begin
            ap_start_d = 1'b1;
        end else if (ap_ready && !auto_restart) begin
            ap_start_d = 1'b0;
        end

        // Sticky status: a pulse coinciding with the clearing read survives it.
        done_d  = ap_done  | (done_q  & ~rd_ctrl);
        ready_d = ap_ready | (ready_q & ~rd_ctrl);

        gie_d = wr_gie ? s_axi_control_wdata[0]   : gie_q;
        ier_d = wr_ier ? s_axi_control_wdata[1:0] : ier_q;

        isr_d = ({ap_ready, ap_done} & ier_q)
              | (isr_q ^ ({2{wr_isr}} & s_axi_control_wdata[1:0]));

        if (wr_lo) ptr_d[31:0]  = merge_wstrb(ptr_q[31:0],  s_axi_control_wdata, s_axi_control_wstrb);
        if (wr_hi) ptr_d[63:32] = merge_wstrb(ptr_q[63:32], s_axi_control_wdata, s_axi_control_wstrb);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_start_q  <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            gie_q       <= 1'b0;
            ier_q       <= '0;
            isr_q       <= '0;
            ptr_q       <= '0;
            interrupt_q <= 1'b0;
        end else begin
            ap_start_q  <= ap_start_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            gie_q       <= gie_d;
            ier_q       <= ier_d;
            isr_q       <= isr_d;
            ptr_q       <= ptr_d;
            interrupt_q <= gie_q & (|isr_q);
        end
    end

    assign s_axi_control_awready = awready_q;
    assign s_axi_control_wready  = wready_q;
    assign s_axi_control_bvalid  = bvalid_q;
    assign s_axi_control_bresp   = 2'b00;
    assign s_axi_control_arready = arready_q;
    assign s_axi_control_rvalid  = rvalid_q;
    assign s_axi_control_rdata   = rdata_q;
    assign s_axi_control_rresp   = 2'b00;
    assign interrupt             = interrupt_q;
    assign ap_start              = ap_start_q;
    assign axi00_ptr0            = ptr_q;

endmodule

// File: tb/tb_kernel_ctrl_s_axi.sv
// Self-checking bench for kernel_ctrl_s_axi: directed scenarios plus randomized traffic against a register-level model.
module tb_kernel_ctrl_s_axi;

    localparam logic [5:0] OFF_CTRL = 6'h00;
    localparam logic [5:0] OFF_GIE  = 6'h04;
    localparam logic [5:0] OFF_IER  = 6'h08;
    localparam logic [5:0] OFF_ISR  = 6'h0C;
    localparam logic [5:0] OFF_LO   = 6'h10;
    localparam logic [5:0] OFF_HI   = 6'h14;
    localparam logic [5:0] OFFS [9] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h3C};

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        interrupt, ap_start, ap_done, ap_idle, ap_ready;
    logic [63:0] axi00_ptr0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model of the programmer-visible state.
    logic [63:0] m_ptr;
    logic        m_gie, m_done, m_ready, m_start, m_auto;
    logic [1:0]  m_ier, m_isr;

    logic        post_w_start;
    logic [63:0] post_w_ptr;

    always #5 ap_clk = ~ap_clk;

    kernel_ctrl_s_axi #(.C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32)) dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .s_axi_control_awvalid (awvalid),
        .s_axi_control_awready (awready),
        .s_axi_control_awaddr  (awaddr),
        .s_axi_control_wvalid  (wvalid),
        .s_axi_control_wready  (wready),
        .s_axi_control_wdata   (wdata),
        .s_axi_control_wstrb   (wstrb),
        .s_axi_control_bvalid  (bvalid),
        .s_axi_control_bready  (bready),
        .s_axi_control_bresp   (bresp),
        .s_axi_control_arvalid (arvalid),
        .s_axi_control_arready (arready),
        .s_axi_control_araddr  (araddr),
        .s_axi_control_rvalid  (rvalid),
        .s_axi_control_rready  (rready),
        .s_axi_control_rdata   (rdata),
        .s_axi_control_rresp   (rresp),
        .interrupt             (interrupt),
        .ap_start              (ap_start),
        .ap_done               (ap_done),
        .ap_idle               (ap_idle),
        .ap_ready              (ap_ready),
        .axi00_ptr0            (axi00_ptr0)
    );

    task automatic model_reset();
        m_ptr = '0; m_gie = 0; m_done = 0; m_ready = 0; m_start = 0; m_auto = 0;
        m_ier = '0; m_isr = '0;
    endtask

    function automatic logic [31:0] model_rd(input logic [11:0] a);
        case (a[5:0])
            OFF_CTRL: return {24'd0, m_auto, 3'd0, m_ready, ap_idle, m_done, m_start};
            OFF_GIE:  return {31'd0, m_gie};
            OFF_IER:  return {30'd0, m_ier};
            OFF_ISR:  return {30'd0, m_isr};
            OFF_LO:   return m_ptr[31:0];
            OFF_HI:   return m_ptr[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_after_read(input logic [11:0] a);
        if (a[5:0] == OFF_CTRL) begin
            m_done  = 1'b0;
            m_ready = 1'b0;
        end
    endtask

    task automatic model_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        case (a[5:0])
            OFF_CTRL: if (s[0]) begin
                if (d[0]) m_start = 1'b1;
`ifdef KCTRL_AUTO_RESTART_EN
                m_auto = d[7];
`endif
            end
            OFF_GIE: if (s[0]) m_gie = d[0];
            OFF_IER: if (s[0]) m_ier = d[1:0];
            OFF_ISR: if (s[0]) m_isr = m_isr ^ d[1:0];
            OFF_LO:  for (int i = 0; i < 4; i++) if (s[i]) m_ptr[8*i +: 8] = d[8*i +: 8];
            OFF_HI:  for (int i = 0; i < 4; i++) if (s[i]) m_ptr[32 + 8*i +: 8] = d[8*i +: 8];
            default: ;
        endcase
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0: return awready;
            1: return wready;
            2: return bvalid;
            3: return arready;
            default: return rvalid;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name, output bit ok);
        int n = 0;
        while (!sig_sel(sel) && n < 100) begin
            @(posedge ap_clk); #1;
            n++;
        end
        ok = sig_sel(sel);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: stayed 0 for 100 cycles, want 1", name);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        awaddr = a; awvalid = 1'b1;
        wait_for(0, "awready", ok);
        if (!ok) begin awvalid = 1'b0; return; end
        @(posedge ap_clk); #1;
        awvalid = 1'b0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        wait_for(1, "wready", ok);
        if (!ok) begin wvalid = 1'b0; return; end
        @(posedge ap_clk); #1;
        wvalid = 1'b0;
        post_w_start = ap_start;
        post_w_ptr   = axi00_ptr0;
        model_wr(a, d, s);
        bready = 1'b1;
        wait_for(2, "bvalid", ok);
        if (!ok) begin bready = 1'b0; return; end
        vectors++;
        if (bresp !== 2'b00) begin
            miscompares++;
            $display("FAIL bresp: got %b want 00", bresp);
        end
        @(posedge ap_clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold, output logic [31:0] d);
        bit ok;
        d = '0;
        araddr = a; arvalid = 1'b1;
        wait_for(3, "arready", ok);
        if (!ok) begin arvalid = 1'b0; return; end
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        vectors++;
        if (rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rvalid_latency: got %b one cycle after AR handshake, want 1", rvalid);
        end
        wait_for(4, "rvalid", ok);
        if (!ok) return;
        repeat (hold) begin @(posedge ap_clk); #1; end
        d = rdata;
        vectors++;
        if (rresp !== 2'b00) begin
            miscompares++;
            $display("FAIL rresp: got %b want 00", rresp);
        end
        rready = 1'b1;
        @(posedge ap_clk); #1;
        rready = 1'b0;
    endtask

    task automatic pulse_done();
        ap_done = 1'b1;
        @(posedge ap_clk); #1;
        ap_done = 1'b0;
        m_done = 1'b1;
        if (m_ier[0]) m_isr[0] = 1'b1;
    endtask

    task automatic pulse_ready();
        ap_ready = 1'b1;
        @(posedge ap_clk); #1;
        ap_ready = 1'b0;
        m_ready = 1'b1;
        if (m_ier[1]) m_isr[1] = 1'b1;
        if (!m_auto) m_start = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        ap_done = 0; ap_idle = 0; ap_ready = 0;
        model_reset();
        repeat (3) begin @(posedge ap_clk); #1; end
        vectors++;
        if ({awready, wready, bvalid, arready, rvalid, interrupt, ap_start} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl_outputs: got %b want 0000000",
                     {awready, wready, bvalid, arready, rvalid, interrupt, ap_start});
        end
        vectors++;
        if (rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        vectors++;
        if (axi00_ptr0 !== 64'd0) begin miscompares++; $display("FAIL reset_ptr: got %h want 0", axi00_ptr0); end
        ap_rst_n = 1'b1;
        repeat (2) begin @(posedge ap_clk); #1; end
        vectors++;
        if ({awready, arready} !== 2'b11) begin
            miscompares++;
            $display("FAIL idle_ready: awready/arready got %b want 11", {awready, arready});
        end
    endtask

    task automatic test_ptr();
        logic [31:0] got;
        axi_write({6'd0, OFF_LO}, 32'h8000_0000, 4'hF);
        vectors++;
        if (post_w_ptr !== 64'h0000_0000_8000_0000) begin
            miscompares++;
            $display("FAIL ptr_lo_latency: got %h want 0000000080000000", post_w_ptr);
        end
        axi_write({6'd0, OFF_HI}, 32'h0000_0001, 4'hF);
        vectors++;
        if (post_w_ptr !== 64'h0000_0001_8000_0000) begin
            miscompares++;
            $display("FAIL ptr_hi_latency: got %h want 0000000180000000", post_w_ptr);
        end
        axi_read({6'd0, OFF_LO}, 0, got);
        vectors++;
        if (got !== model_rd({6'd0, OFF_LO})) begin
            miscompares++; $display("FAIL ptr_lo_read: got %h want %h", got, model_rd({6'd0, OFF_LO}));
        end
        axi_read({6'd0, OFF_HI}, 2, got);
        vectors++;
        if (got !== 32'h0000_0001) begin
            miscompares++; $display("FAIL ptr_hi_read: got %h want 00000001", got);
        end
    endtask

    task automatic test_start_done();
        logic [31:0] got, exp;
        ap_idle = 1'b0;
        axi_write({6'd0, OFF_CTRL}, 32'h1, 4'hF);
        vectors++;
        if (post_w_start !== 1'b1) begin
            miscompares++; $display("FAIL start_latency: ap_start got %b want 1", post_w_start);
        end
        repeat (2) begin @(posedge ap_clk); #1; end
        ap_ready = 1'b1;
        vectors++;
        if (ap_start !== 1'b1) begin
            miscompares++; $display("FAIL start_held: ap_start got %b want 1", ap_start);
        end
        ap_ready = 1'b0;
        pulse_ready();
        vectors++;
        if (ap_start !== m_start) begin
            miscompares++; $display("FAIL start_clear: ap_start got %b want %b", ap_start, m_start);
        end
        repeat (4) begin @(posedge ap_clk); #1; end
        pulse_done();
        exp = model_rd({6'd0, OFF_CTRL});
        axi_read({6'd0, OFF_CTRL}, 1, got);
        model_after_read({6'd0, OFF_CTRL});
        vectors++;
        if (got !== exp || got !== 32'h0000_000A) begin
            miscompares++; $display("FAIL ctrl_read1: got %h want %h", got, exp);
        end
        ap_idle = 1'b1;
        exp = model_rd({6'd0, OFF_CTRL});
        axi_read({6'd0, OFF_CTRL}, 0, got);
        model_after_read({6'd0, OFF_CTRL});
        vectors++;
        if (got !== exp || got !== 32'h0000_0004) begin
            miscompares++; $display("FAIL ctrl_read2: got %h want %h", got, exp);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] got;
        axi_write({6'd0, OFF_GIE}, 32'h1, 4'h1);
        axi_write({6'd0, OFF_IER}, 32'h1, 4'h1);
        axi_write({6'd0, OFF_CTRL}, 32'h1, 4'h1);
        pulse_done();
        vectors++;
        if (interrupt !== 1'b0) begin
            miscompares++; $display("FAIL irq_early: interrupt got %b want 0", interrupt);
        end
        @(posedge ap_clk); #1;
        vectors++;
        if (interrupt !== 1'b1) begin
            miscompares++; $display("FAIL irq_assert: interrupt got %b want 1", interrupt);
        end
        axi_read({6'd0, OFF_ISR}, 0, got);
        vectors++;
        if (got !== model_rd({6'd0, OFF_ISR})) begin
            miscompares++; $display("FAIL isr_read: got %h want %h", got, model_rd({6'd0, OFF_ISR}));
        end
        axi_write({6'd0, OFF_ISR}, 32'h1, 4'h1);
        vectors++;
        if (interrupt !== (m_gie & (|m_isr))) begin
            miscompares++; $display("FAIL irq_clear: interrupt got %b want %b", interrupt, m_gie & (|m_isr));
        end
    endtask

    task automatic test_read_collision();
        logic [31:0] got, exp;
        bit ok;
        axi_read({6'd0, OFF_CTRL}, 0, got);
        model_after_read({6'd0, OFF_CTRL});
        araddr = {6'd0, OFF_CTRL};
        arvalid = 1'b1;
        wait_for(3, "arready", ok);
        exp = model_rd({6'd0, OFF_CTRL});
        ap_done = 1'b1;
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        ap_done = 1'b0;
        model_after_read({6'd0, OFF_CTRL});
        m_done = 1'b1;
        if (m_ier[0]) m_isr[0] = 1'b1;
        wait_for(4, "rvalid", ok);
        got = rdata;
        rready = 1'b1;
        @(posedge ap_clk); #1;
        rready = 1'b0;
        vectors++;
        if (got !== exp) begin
            miscompares++; $display("FAIL collide_read: got %h want %h", got, exp);
        end
        exp = model_rd({6'd0, OFF_CTRL});
        axi_read({6'd0, OFF_CTRL}, 0, got);
        model_after_read({6'd0, OFF_CTRL});
        vectors++;
        if (got !== exp || got[1] !== 1'b1) begin
            miscompares++; $display("FAIL collide_sticky: got %h want %h", got, exp);
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] got;
        axi_write({6'd0, OFF_LO}, 32'h0, 4'hF);
        axi_write({6'd0, OFF_LO}, 32'hFFFF_FFFF, 4'b0010);
        axi_read({6'd0, OFF_LO}, 0, got);
        vectors++;
        if (got !== 32'h0000_FF00 || got !== model_rd({6'd0, OFF_LO})) begin
            miscompares++; $display("FAIL wstrb_lo: got %h want 0000ff00", got);
        end
        axi_write({6'd0, OFF_HI}, 32'hA5C3_5A3C, 4'b1001);
        axi_read({6'd0, OFF_HI}, 0, got);
        vectors++;
        if (got !== model_rd({6'd0, OFF_HI})) begin
            miscompares++; $display("FAIL wstrb_hi: got %h want %h", got, model_rd({6'd0, OFF_HI}));
        end
    endtask

    task automatic test_random();
        logic [31:0] r, d, got, exp;
        logic [11:0] a;
        logic [3:0]  s;
        int op;
        for (int it = 0; it < 80; it++) begin
            r  = $urandom;
            a  = {r[11:6], OFFS[$urandom_range(0, 8)]};
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    d = $urandom;
                    s = 4'($urandom_range(0, 15));
                    axi_write(a, d, s);
                end
                1: begin
                    exp = model_rd(a);
                    axi_read(a, $urandom_range(0, 2), got);
                    model_after_read(a);
                    vectors++;
                    if (got !== exp) begin
                        miscompares++; $display("FAIL rand_read: addr %h got %h want %h", a, got, exp);
                    end
                end
                2: begin
                    if ($urandom_range(0, 1) == 1) pulse_done();
                    else pulse_ready();
                    @(posedge ap_clk); #1;
                end
                default: begin
                    ap_idle = ~ap_idle;
                    @(posedge ap_clk); #1;
                end
            endcase
            vectors++;
            if ({ap_start, interrupt, axi00_ptr0} !== {m_start, m_gie & (|m_isr), m_ptr}) begin
                miscompares++;
                $display("FAIL rand_outputs: start/irq/ptr got %b/%b/%h want %b/%b/%h",
                         ap_start, interrupt, axi00_ptr0, m_start, m_gie & (|m_isr), m_ptr);
            end
        end
    endtask

    task automatic test_reset_midread();
        logic [31:0] got, exp;
        bit ok;
        axi_write({6'd0, OFF_HI}, 32'hDEAD_BEEF, 4'hF);
        axi_write({6'd0, OFF_CTRL}, 32'h81, 4'h1);
        araddr = {6'd0, OFF_HI};
        arvalid = 1'b1;
        wait_for(3, "arready", ok);
        @(posedge ap_clk); #1;
        arvalid = 1'b0;
        vectors++;
        if (rvalid !== 1'b1) begin
            miscompares++; $display("FAIL midread_rvalid: got %b want 1", rvalid);
        end
        #2 ap_rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({rvalid, bvalid, ap_start, interrupt} !== 4'b0000 || axi00_ptr0 !== 64'd0 || rdata !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset: rvalid/bvalid/start/irq got %b ptr %h rdata %h want 0",
                     {rvalid, bvalid, ap_start, interrupt}, axi00_ptr0, rdata);
        end
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        repeat (2) begin @(posedge ap_clk); #1; end
        exp = model_rd({6'd0, OFF_CTRL});
        axi_read({6'd0, OFF_CTRL}, 0, got);
        model_after_read({6'd0, OFF_CTRL});
        vectors++;
        if (got !== exp || got[7] !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_ctrl: got %h want %h", got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ptr();
        test_start_done();
        test_interrupt();
        test_read_collision();
        test_wstrb();
        test_random();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kernel_ctrl_s_axi.md
Name: kernel_ctrl_s_axi

Overview:
AXI4-Lite control slave that sits directly upstream of the kernel top. The host programs argument registers and starts the kernel through it. It drives ap_start and the 64-bit pointer argument (axi00_ptr0) into the kernel, and takes back ap_idle/ap_done/ap_ready. It exposes the standard kernel control register map plus an interrupt line.

Parameters:
C_S_AXI_ADDR_WIDTH, 12, control-port byte address width; address decode uses bits [5:0], upper bits ignored
C_S_AXI_DATA_WIDTH, 32, control-port data width; fixed at 32, other values are unsupported

Ports:
ap_clk  in  1  kernel clock; all logic in this domain
ap_rst_n  in  1  asynchronous active-low reset
s_axi_control_awvalid  in  1  write-address valid
s_axi_control_awready  out  1  write-address ready
s_axi_control_awaddr  in  C_S_AXI_ADDR_WIDTH  write byte address
s_axi_control_wvalid  in  1  write-data valid
s_axi_control_wready  out  1  write-data ready
s_axi_control_wdata  in  32  write data
s_axi_control_wstrb  in  4  byte enables
s_axi_control_bvalid  out  1  write response valid
s_axi_control_bready  in  1  write response ready
s_axi_control_bresp  out  2  always 2'b00 (OKAY)
s_axi_control_arvalid  in  1  read-address valid
s_axi_control_arready  out  1  read-address ready
s_axi_control_araddr  in  C_S_AXI_ADDR_WIDTH  read byte address
s_axi_control_rvalid  out  1  read data valid
s_axi_control_rready  in  1  read data ready
s_axi_control_rdata  out  32  read data
s_axi_control_rresp  out  2  always 2'b00 (OKAY)
interrupt  out  1  level interrupt to host
ap_start  out  1  start request to kernel (level)
ap_done  in  1  one-cycle done pulse from kernel
ap_idle  in  1  kernel idle level
ap_ready  in  1  one-cycle ready pulse from kernel
axi00_ptr0  out  64  buffer base address argument

Behaviour:
- Register map (byte offsets):
  - 0x00 AP_CTRL: bit0 ap_start (RW), bit1 ap_done (RO, clear-on-read), bit2 ap_idle (RO, live), bit3 ap_ready (RO, clear-on-read), bit7 auto_restart (RW).
  - 0x04 GIE: bit0 global interrupt enable.
  - 0x08 IER: bit0 done enable, bit1 ready enable.
  - 0x0C ISR: bit0 done, bit1 ready; toggle-on-write-1.
  - 0x10 PTR0_LO, 0x14 PTR0_HI.
  - Unmapped offsets read 0; writes to them are ignored.
- Write FSM, states WRIDLE, WRDATA, WRRESP; reset state WRIDLE.
  - WRIDLE: awready=1; awvalid captures the address and moves to WRDATA.
  - WRDATA: wready=1; wvalid performs the register write and moves to WRRESP.
  - WRRESP: bvalid=1; bready returns to WRIDLE.
  - aw and w are never accepted in the same cycle.
- Read FSM, states RDIDLE, RDDATA; reset state RDIDLE.
  - RDIDLE: arready=1; arvalid registers rdata from the current register state and moves to RDDATA, so rvalid asserts the next cycle.
  - RDDATA: rvalid and rdata hold until rready, then return to RDIDLE.
- wstrb is honoured per byte for PTR0_LO/HI. For AP_CTRL/GIE/IER/ISR, only wstrb[0] enables the write.
- ap_start:
  - Set when AP_CTRL is written with wdata[0]=1.
  - Cleared on the cycle after ap_ready=1, unless auto_restart=1, in which case it stays set.
  - Writing 0 has no effect.
- ap_done sticky bit:
  - Set on the ap_done pulse.
  - Cleared when an AP_CTRL read is accepted (arvalid&arready at 0x00).
  - Simultaneous set and clear: the set wins, bit stays 1.
  - Same rules apply to the ap_ready sticky bit.
- ISR[n]:
  - Set when the event pulse occurs and IER[n]=1.
  - Toggled by a write-1; a set in the same cycle wins.
  - interrupt = GIE & (ISR[0] | ISR[1]), registered (one cycle after the ISR change).
- Reset (asynchronous assert, mid-transaction included):
  - Both FSMs return to idle.
  - Outputs: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rdata=0, interrupt=0, ap_start=0, axi00_ptr0=0.
  - All registers return to 0.
  - The in-flight transaction is dropped with no response.
- Fixed latencies:
  - ap_start asserts 1 cycle after the AP_CTRL write handshake (wvalid&wready).
  - axi00_ptr0 updates 1 cycle after its write handshake.

Optional Feature:
- Macro KCTRL_AUTO_RESTART_EN.
- Defined: AP_CTRL bit7 is implemented, with auto-restart behaviour as above.
- Undefined: bit7 reads 0, writes are ignored, and ap_start always clears after ap_ready.

Decomposition:
- Shared package kernel_ctrl_pkg holds:
  - Register offset localparams: ADDR_AP_CTRL, ADDR_GIE, ADDR_IER, ADDR_ISR, ADDR_PTR0_LO, ADDR_PTR0_HI.
  - AP_CTRL bit-index constants.
  - The typedef enums for the write and read FSM states.
- Single module, no sub-module; the register file and both FSMs are compact enough inline.

Test Plan:
- Write 0x10=0x8000_0000, 0x14=0x0000_0001 -> axi00_ptr0=0x0000_0001_8000_0000; readback matches; bresp/rresp=0.
- Write AP_CTRL=0x1; kernel pulses ap_ready, then ap_done 5 cycles later -> ap_start falls the cycle after ap_ready; AP_CTRL read returns 0x0A then 0x04 (ap_done and ap_ready cleared by the first read, ap_idle=1).
- GIE=1, IER=1, start, ap_done pulse -> interrupt=1 two cycles after the pulse; write ISR=0x1 -> interrupt=0.
- ap_done pulse in the same cycle as an AP_CTRL read handshake -> that read returns bit1 per pre-pulse state and the next read returns bit1=1.
- Write PTR0_LO=0xFFFF_FFFF with wstrb=4'b0010 -> register reads 0x0000_FF00.
- Assert ap_rst_n=0 while rvalid=1 and rready=0 -> rvalid, ap_start and axi00_ptr0 go to 0 immediately; with the macro defined, AP_CTRL bit7 reads 0 after reset.
